// File: rtl/reg_writeback_queue_if.sv
// Producer-side handshake bundle: ALU results and load returns offered to the writeback queue.
// valid/ready: a result transfers on a rising edge where valid && ready; the producer holds it stable until then.
interface reg_writeback_queue_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready
  );
endinterface

// File: rtl/reg_writeback_queue.sv
// In-order writeback FIFO feeding the integer register file write port,
// with combinational youngest-match forwarding of pending results.
module reg_writeback_queue #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  reg_writeback_queue_if.slave     prod,
  input  logic                     wb_stall,
  output logic                     RegWrite,
  output logic [ADDR_W-1:0]        RD,
  output logic [DATA_W-1:0]        WriteData,
  input  logic [ADDR_W-1:0]        q_rs1,
  input  logic [ADDR_W-1:0]        q_rs2,
  output logic                     q_hit1,
  output logic                     q_hit2,
  output logic [DATA_W-1:0]        q_data1,
  output logic [DATA_W-1:0]        q_data2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              has_room, mem_fire, alu_fire, push, pop;
  logic [ADDR_W-1:0] in_rd;
  logic [DATA_W-1:0] in_data;

  // Readiness looks only at the pre-edge occupancy, so a full queue never passes through.
  assign has_room       = count < CNT_W'(DEPTH);
  assign prod.mem_ready = has_room;
  assign prod.alu_ready = has_room & ~prod.mem_valid;
  assign mem_fire       = prod.mem_valid & has_room;
  assign alu_fire       = prod.alu_valid & prod.alu_ready;
  assign in_rd          = mem_fire ? prod.mem_rd   : prod.alu_rd;
  assign in_data        = mem_fire ? prod.mem_data : prod.alu_data;
  // x0 results complete the handshake but are never stored.
  assign push           = (mem_fire | alu_fire) & (in_rd != '0);
  assign pop            = (count != '0) & ~wb_stall;
  assign empty          = (count == '0) & ~RegWrite;

  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wr_ptr]   <= in_rd;
      data_q[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      RegWrite  <= 1'b0;
      RD        <= '0;
      WriteData <= '0;
    end else begin
      RegWrite <= pop;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        RD        <= rd_q[rd_ptr];
        WriteData <= data_q[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Scan oldest (output stage) to newest so the youngest match overwrites older ones.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] q);
    logic [DATA_W:0]  r;
    logic [PTR_W-1:0] idx;
    r = '0;
    if (q != '0) begin
      if (RegWrite && (RD == q)) r = {1'b1, WriteData};
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr + PTR_W'(i);
        if ((CNT_W'(i) < count) && (rd_q[idx] == q)) r = {1'b1, data_q[idx]};
      end
    end
    return r;
  endfunction

  assign {q_hit1, q_data1} = lookup(q_rs1);
  assign {q_hit2, q_data2} = lookup(q_rs2);
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Bench for reg_writeback_queue: directed scenarios plus randomized traffic checked
// against a queue-based model of pending writes.
module tb_reg_writeback_queue;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;

  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  wb_stall;
  logic                  RegWrite;
  logic [ADDR_W-1:0]     RD;
  logic [DATA_W-1:0]     WriteData;
  logic [ADDR_W-1:0]     q_rs1, q_rs2;
  logic                  q_hit1, q_hit2;
  logic [DATA_W-1:0]     q_data1, q_data2;
  logic [$clog2(DEPTH):0] count;
  logic                  empty;

  int tests_run = 0;
  int fails = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  reg_writeback_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) prod_if ();

  reg_writeback_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .prod(prod_if), .wb_stall(wb_stall),
    .RegWrite(RegWrite), .RD(RD), .WriteData(WriteData),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_hit1(q_hit1), .q_hit2(q_hit2),
    .q_data1(q_data1), .q_data2(q_data2), .count(count), .empty(empty)
  );

  task automatic drive_alu(input logic v, input int rd, input logic [DATA_W-1:0] d);
    prod_if.alu_valid = v;
    prod_if.alu_rd    = ADDR_W'(rd);
    prod_if.alu_data  = d;
  endtask

  task automatic drive_mem(input logic v, input int rd, input logic [DATA_W-1:0] d);
    prod_if.mem_valid = v;
    prod_if.mem_rd    = ADDR_W'(rd);
    prod_if.mem_data  = d;
  endtask

  task automatic test_reset;
    wb_stall = 1'b0; q_rs1 = '0; q_rs2 = '0;
    drive_mem(1'b0, 0, '0);
    drive_alu(1'b1, 5, 64'hAA);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (RegWrite !== 1'b0) begin fails++; $display("FAIL reset_regwrite: got %0h expected 0", RegWrite); end
    tests_run++; if (RD !== '0) begin fails++; $display("FAIL reset_rd: got %0h expected 0", RD); end
    tests_run++; if (WriteData !== '0) begin fails++; $display("FAIL reset_wdata: got %0h expected 0", WriteData); end
    tests_run++; if (count !== '0) begin fails++; $display("FAIL reset_count: got %0d expected 0", count); end
    tests_run++; if (prod_if.alu_ready !== 1'b1) begin fails++; $display("FAIL reset_alu_ready: got %0h expected 1", prod_if.alu_ready); end
    reset = 1'b1;
    @(posedge clk); #1;
    drive_alu(1'b0, 0, '0);
    tests_run++; if (count !== 3'd1) begin fails++; $display("FAIL first_accept_count: got %0d expected 1", count); end
    tests_run++; if (RegWrite !== 1'b0) begin fails++; $display("FAIL first_accept_regwrite: got %0h expected 0", RegWrite); end
    @(posedge clk); #1;
    tests_run++; if ({RegWrite, RD, WriteData} !== {1'b1, 5'd5, 64'hAA}) begin fails++; $display("FAIL first_write: got %0h/%0d/%0h expected 1/5/aa", RegWrite, RD, WriteData); end
    @(posedge clk); #1;
    tests_run++; if ({RegWrite, empty} !== 2'b01) begin fails++; $display("FAIL first_write_end: got regwrite=%0h empty=%0h expected 0/1", RegWrite, empty); end
  endtask

  task automatic test_priority;
    wb_stall = 1'b1;
    drive_mem(1'b1, 3, 64'd7);
    drive_alu(1'b1, 4, 64'd9);
    for (int c = 0; c < 6; c++) begin
      #1;
      tests_run++; if (prod_if.mem_ready !== (c < 4)) begin fails++; $display("FAIL prio_mem_ready[%0d]: got %0h expected %0h", c, prod_if.mem_ready, (c < 4)); end
      tests_run++; if (prod_if.alu_ready !== 1'b0) begin fails++; $display("FAIL prio_alu_ready[%0d]: got %0h expected 0", c, prod_if.alu_ready); end
      @(posedge clk); #1;
      tests_run++; if (count !== 3'((c < 4) ? c + 1 : 4)) begin fails++; $display("FAIL prio_count[%0d]: got %0d expected %0d", c, count, (c < 4) ? c + 1 : 4); end
    end
    drive_mem(1'b0, 0, '0);
    #1;
    tests_run++; if (prod_if.alu_ready !== 1'b0) begin fails++; $display("FAIL full_alu_ready: got %0h expected 0", prod_if.alu_ready); end
    drive_alu(1'b0, 0, '0);
    wb_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      tests_run++; if ({RegWrite, RD, WriteData} !== {1'b1, 5'd3, 64'd7}) begin fails++; $display("FAIL drain_write[%0d]: got %0h/%0d/%0h expected 1/3/7", k, RegWrite, RD, WriteData); end
    end
    @(posedge clk); #1;
    tests_run++; if ({RegWrite, count} !== {1'b0, 3'd0}) begin fails++; $display("FAIL drain_end: got regwrite=%0h count=%0d expected 0/0", RegWrite, count); end
  endtask

  task automatic test_x0;
    int pulses;
    pulses = 0;
    q_rs1 = '0; q_rs2 = 5'd1;
    drive_alu(1'b1, 0, 64'hFFFF);
    #1;
    tests_run++; if (prod_if.alu_ready !== 1'b1) begin fails++; $display("FAIL x0_ready: got %0h expected 1", prod_if.alu_ready); end
    @(posedge clk); #1;
    tests_run++; if ({count, RegWrite} !== {3'd0, 1'b0}) begin fails++; $display("FAIL x0_not_stored: got count=%0d regwrite=%0h expected 0/0", count, RegWrite); end
    drive_alu(1'b1, 1, 64'd2);
    @(posedge clk); #1;
    drive_alu(1'b0, 0, '0);
    #1;
    tests_run++; if ({q_hit1, q_data1} !== {1'b0, 64'd0}) begin fails++; $display("FAIL x0_query: got %0h/%0h expected 0/0", q_hit1, q_data1); end
    tests_run++; if ({q_hit2, q_data2} !== {1'b1, 64'd2}) begin fails++; $display("FAIL x1_query: got %0h/%0h expected 1/2", q_hit2, q_data2); end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (RegWrite) begin
        pulses++;
        tests_run++; if ({RD, WriteData} !== {5'd1, 64'd2}) begin fails++; $display("FAIL x0_write: got %0d/%0h expected 1/2", RD, WriteData); end
      end
    end
    tests_run++; if (pulses !== 1) begin fails++; $display("FAIL x0_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_forward;
    wb_stall = 1'b1; q_rs1 = 5'd8; q_rs2 = 5'd9;
    drive_alu(1'b1, 8, 64'd1);
    @(posedge clk); #1;
    tests_run++; if ({q_hit1, q_data1} !== {1'b1, 64'd1}) begin fails++; $display("FAIL fwd_first: got %0h/%0h expected 1/1", q_hit1, q_data1); end
    drive_alu(1'b1, 8, 64'd2);
    @(posedge clk); #1;
    drive_alu(1'b0, 0, '0);
    #1;
    tests_run++; if ({q_hit1, q_data1} !== {1'b1, 64'd2}) begin fails++; $display("FAIL fwd_youngest: got %0h/%0h expected 1/2", q_hit1, q_data1); end
    tests_run++; if ({q_hit2, q_data2} !== {1'b0, 64'd0}) begin fails++; $display("FAIL fwd_miss: got %0h/%0h expected 0/0", q_hit2, q_data2); end
    wb_stall = 1'b0;
    @(posedge clk); #1;
    tests_run++; if ({RegWrite, WriteData, q_hit1, q_data1} !== {1'b1, 64'd1, 1'b1, 64'd2}) begin fails++; $display("FAIL fwd_pop1: got %0h/%0h hit=%0h/%0h expected 1/1 hit=1/2", RegWrite, WriteData, q_hit1, q_data1); end
    @(posedge clk); #1;
    tests_run++; if ({RegWrite, WriteData, q_hit1, q_data1} !== {1'b1, 64'd2, 1'b1, 64'd2}) begin fails++; $display("FAIL fwd_pop2: got %0h/%0h hit=%0h/%0h expected 1/2 hit=1/2", RegWrite, WriteData, q_hit1, q_data1); end
    @(posedge clk); #1;
    tests_run++; if ({RegWrite, q_hit1, q_data1} !== {1'b0, 1'b0, 64'd0}) begin fails++; $display("FAIL fwd_gone: got %0h hit=%0h/%0h expected 0 hit=0/0", RegWrite, q_hit1, q_data1); end
  endtask

  task automatic test_back_to_back;
    int writes;
    logic [ADDR_W+DATA_W-1:0] exp;
    writes = 0;
    exp_q.delete();
    wb_stall = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      if (k <= 10) drive_alu(1'b1, k, DATA_W'(k * 3));
      else drive_alu(1'b0, 0, '0);
      #1;
      if (k <= 10) begin
        tests_run++; if (prod_if.alu_ready !== 1'b1) begin fails++; $display("FAIL stream_ready[%0d]: got %0h expected 1", k, prod_if.alu_ready); end
        exp_q.push_back({ADDR_W'(k), DATA_W'(k * 3)});
      end
      @(posedge clk); #1;
      tests_run++; if (count > 3'd1) begin fails++; $display("FAIL stream_count[%0d]: got %0d expected <=1", k, count); end
      tests_run++; if (RegWrite !== (k >= 2 && k <= 11)) begin fails++; $display("FAIL stream_regwrite[%0d]: got %0h expected %0h", k, RegWrite, (k >= 2 && k <= 11)); end
      if (RegWrite) begin
        writes++;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        tests_run++; if ({RD, WriteData} !== exp) begin fails++; $display("FAIL stream_order[%0d]: got %0d/%0h expected %0d/%0h", k, RD, WriteData, exp[DATA_W +: ADDR_W], exp[DATA_W-1:0]); end
      end
    end
    tests_run++; if (writes !== 10 || exp_q.size() != 0) begin fails++; $display("FAIL stream_total: got %0d writes, %0d left expected 10/0", writes, exp_q.size()); end
  endtask

  task automatic test_reset_mid_drain;
    wb_stall = 1'b1; q_rs1 = 5'd12;
    for (int i = 0; i < 3; i++) begin
      drive_alu(1'b1, 11 + i, DATA_W'(100 + i));
      @(posedge clk); #1;
    end
    drive_alu(1'b0, 0, '0);
    tests_run++; if (count !== 3'd3) begin fails++; $display("FAIL mid_count: got %0d expected 3", count); end
    wb_stall = 1'b0;
    @(posedge clk); #1;
    tests_run++; if ({RegWrite, RD} !== {1'b1, 5'd11}) begin fails++; $display("FAIL mid_first: got %0h/%0d expected 1/11", RegWrite, RD); end
    #1 reset = 1'b0;
    #1;
    tests_run++; if ({RegWrite, RD, WriteData, count, empty} !== {1'b0, 5'd0, 64'd0, 3'd0, 1'b1}) begin fails++; $display("FAIL mid_reset: got %0h/%0d/%0h/%0d/%0h expected 0/0/0/0/1", RegWrite, RD, WriteData, count, empty); end
    tests_run++; if (q_hit1 !== 1'b0) begin fails++; $display("FAIL mid_reset_fwd: got %0h expected 0", q_hit1); end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      tests_run++; if ({RegWrite, count} !== {1'b0, 3'd0}) begin fails++; $display("FAIL post_reset[%0d]: got %0h/%0d expected 0/0", k, RegWrite, count); end
    end
  endtask

  task automatic test_random;
    ent_t m_fifo[$];
    ent_t e;
    logic m_wr;
    logic [ADDR_W-1:0] m_rd;
    logic [DATA_W-1:0] m_data;
    logic mv, av, room, eh;
    logic [ADDR_W-1:0] q;
    logic [DATA_W-1:0] ed;
    m_wr = 1'b0; m_rd = '0; m_data = '0;
    for (int c = 0; c < 400; c++) begin
      mv = ($urandom_range(0, 3) == 0);
      av = ($urandom_range(0, 1) == 1);
      drive_mem(mv, $urandom_range(0, 7), {$urandom, $urandom});
      drive_alu(av, $urandom_range(0, 7), {$urandom, $urandom});
      wb_stall = ($urandom_range(0, 3) == 0);
      q_rs1 = ADDR_W'($urandom_range(0, 7));
      q_rs2 = ADDR_W'($urandom_range(0, 31));
      #1;
      room = (m_fifo.size() < DEPTH);
      tests_run++; if (prod_if.mem_ready !== room) begin fails++; $display("FAIL rnd_mem_ready[%0d]: got %0h expected %0h", c, prod_if.mem_ready, room); end
      tests_run++; if (prod_if.alu_ready !== (room && !mv)) begin fails++; $display("FAIL rnd_alu_ready[%0d]: got %0h expected %0h", c, prod_if.alu_ready, room && !mv); end
      for (int p = 0; p < 2; p++) begin
        q = (p == 0) ? q_rs1 : q_rs2;
        eh = 1'b0; ed = '0;
        if (q != '0) begin
          if (m_wr && m_rd == q) begin eh = 1'b1; ed = m_data; end
          foreach (m_fifo[i]) if (m_fifo[i].rd == q) begin eh = 1'b1; ed = m_fifo[i].data; end
        end
        if (p == 0) begin
          tests_run++; if ({q_hit1, q_data1} !== {eh, ed}) begin fails++; $display("FAIL rnd_fwd1[%0d]: got %0h/%0h expected %0h/%0h", c, q_hit1, q_data1, eh, ed); end
        end else begin
          tests_run++; if ({q_hit2, q_data2} !== {eh, ed}) begin fails++; $display("FAIL rnd_fwd2[%0d]: got %0h/%0h expected %0h/%0h", c, q_hit2, q_data2, eh, ed); end
        end
      end
      if (m_fifo.size() > 0 && !wb_stall) begin
        e = m_fifo.pop_front();
        m_wr = 1'b1; m_rd = e.rd; m_data = e.data;
      end else begin
        m_wr = 1'b0;
      end
      if (mv && room && prod_if.mem_rd != '0) m_fifo.push_back('{rd: prod_if.mem_rd, data: prod_if.mem_data});
      else if (!mv && av && room && prod_if.alu_rd != '0) m_fifo.push_back('{rd: prod_if.alu_rd, data: prod_if.alu_data});
      @(posedge clk); #1;
      tests_run++; if ({RegWrite, RD, WriteData} !== {m_wr, m_rd, m_data}) begin fails++; $display("FAIL rnd_write[%0d]: got %0h/%0d/%0h expected %0h/%0d/%0h", c, RegWrite, RD, WriteData, m_wr, m_rd, m_data); end
      tests_run++; if ({count, empty} !== {3'(m_fifo.size()), (m_fifo.size() == 0) && !m_wr}) begin fails++; $display("FAIL rnd_count[%0d]: got %0d/%0h expected %0d/%0h", c, count, empty, m_fifo.size(), (m_fifo.size() == 0) && !m_wr); end
    end
    drive_mem(1'b0, 0, '0);
    drive_alu(1'b0, 0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_priority();
    test_x0();
    test_forward();
    test_back_to_back();
    test_reset_mid_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule

// File: doc/reg_writeback_queue.md
Name: reg_writeback_queue

Overview:
- Write-side front end for the 64-bit, 32-entry integer register file.
- Accepts retiring results from two producers: the ALU path and the load-return path. Buffers them in an in-order FIFO.
- Drives the register file write port (RegWrite, RD, WriteData) with one registered write per cycle.
- Provides combinational forwarding of pending results to the read stage, so reads of not-yet-written registers see the correct value.

Parameters:
- DATA_W, 64, result/write data width
- ADDR_W, 5, register index width
- DEPTH, 4, FIFO entries (power of two, ≥2)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- alu_valid  input  1  ALU result offered
- alu_rd  input  ADDR_W  ALU destination register
- alu_data  input  DATA_W  ALU result
- alu_ready  output  1  ALU result accepted this cycle when alu_valid&alu_ready
- mem_valid  input  1  load result offered
- mem_rd  input  ADDR_W  load destination register
- mem_data  input  DATA_W  load result
- mem_ready  output  1  load result accepted when mem_valid&mem_ready
- wb_stall  input  1  hold drain; no pop while high
- RegWrite  output  1  register file write enable (registered)
- RD  output  ADDR_W  register file write index (registered)
- WriteData  output  DATA_W  register file write data (registered)
- q_rs1, q_rs2  input  ADDR_W  forwarding query indices
- q_hit1, q_hit2  output  1  pending write to queried register exists
- q_data1, q_data2  output  DATA_W  youngest pending value for queried register; 0 when no hit
- count  output  $clog2(DEPTH)+1  occupied entries
- empty  output  1  count==0 and RegWrite==0

Behaviour:
- Reset (reset==0, asynchronous): count=0, read/write pointers=0, RegWrite=0, RD=0, WriteData=0.
  - All queued entries are discarded, including a reset arriving mid-drain; no partial write escapes.
  - Outputs stay at reset values until the first rising edge after reset returns high.
- Enqueue (at most one per cycle):
  - mem_ready = (count<DEPTH).
  - alu_ready = (count<DEPTH) & ~mem_valid. Load return has fixed priority because it cannot be back-pressured upstream for long.
  - Readiness uses count before this edge's pop: no same-cycle pass-through when full.
- x0 rule: an accepted result with rd==0 completes the handshake but is not stored. count is unchanged and no RegWrite is ever issued for index 0.
- Pop: when count>0 and wb_stall==0, the head entry is loaded into RD/WriteData with RegWrite=1 at that edge, and the read pointer advances.
  - Otherwise RegWrite=0 at that edge; RD/WriteData hold their last values.
  - RegWrite is high for exactly one cycle per entry.
- Latency: a result accepted at edge E into an empty queue with wb_stall=0 pops at edge E+1. RegWrite is high during cycle E+1..E+2, and the register file captures it at edge E+2. Sustained throughput is one write per cycle.
- Simultaneous enqueue and pop: count unchanged, both pointers advance. Pointers wrap modulo DEPTH; full/empty is determined from count.
- Ordering: writes reach the register file in acceptance order. Two queued writes to the same rd are both issued; the later one is issued last.
- Forwarding (combinational, per port):
  - Search the valid FIFO entries plus the output stage (if RegWrite==1) for rd==q_rsN, with q_rsN≠0.
  - The youngest match wins, with age order newest FIFO entry > ... > head > output stage.
  - q_rs==0 always returns hit=0, data=0.
- Enqueue and forwarding are independent: a value accepted at edge E is visible to queries starting in cycle E..E+1 (after the edge).

Test Plan:
- Reset: hold reset=0 with alu_valid=1 -> RegWrite=0, RD=0, WriteData=0, count=0, alu_ready=1. Release reset, accept alu rd=5 data=0xAA -> RegWrite=1 RD=5 WriteData=0xAA one edge later.
- Priority/backpressure: wb_stall=1, offer mem rd=3 data=7 and alu rd=4 data=9 together each cycle.
  - Loads only are accepted until count=4; then mem_ready=0 and alu_ready=0.
  - Release stall -> four writes to x3, data 7, on consecutive cycles.
- x0 drop: accept alu rd=0 data=0xFFFF, then rd=1 data=2 -> exactly one RegWrite pulse (RD=1, WriteData=2). q_rs1=0 gives hit=0.
- Forwarding youngest-wins: wb_stall=1, enqueue rd=8 data=1, then rd=8 data=2 -> q_rs1=8 gives hit=1, data=2. Pop both; after the second RegWrite cycle ends, hit=0.
- Wrap/throughput: wb_stall=0, stream 10 back-to-back ALU results rd=1..10, data=rd*3 -> 10 consecutive RegWrite cycles in order, count never exceeds 1, pointers wrap without loss.
- Reset mid-drain: three entries queued with stall=1; assert reset for one cycle between edges -> RegWrite drops immediately, count=0. No further writes after release.
